// File: rtl/instruction_fetch_pkg.sv
// Shared fetch configuration: word size, the NOP encoding, the default
// reset vector, the FSM state type and the fetch buffer entry layout.
package instruction_fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
  localparam logic [XLEN-1:0] INSTR_BYTES      = XLEN'(4);

  typedef enum logic [1:0] {
    S_RUN,
    S_FAULT,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch output buffer: a shift-register FIFO whose head is always slot 0,
// so the head data comes straight from a register.
// Ports:
//   clk        rising-edge clock
//   clear      synchronous clear (drops all entries, zeroes storage)
//   push, din  write an entry at the tail
//   pop        drop the head entry (ignored when empty)
//   valid      buffer is non-empty
//   head       head entry
//   count      number of stored entries
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic                         valid,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  int unsigned      wr_idx;

  assign do_pop = pop && (count != '0);
  assign valid  = (count != '0);
  assign head   = mem[0];

  // With a simultaneous pop the tail moves down one slot before the write.
  always_comb begin
    wr_idx = 32'(count);
    if (do_pop) wr_idx = wr_idx - 1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) mem[i] <= mem[i+1];
        mem[DEPTH-1] <= '0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && i == wr_idx) mem[i] <= din;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: keeps the pc, issues one-cycle-latency reads to
// instruction memory, buffers responses for decode, and handles redirects
// (including misaligned targets, which produce a single faulting entry and
// then halt fetch until the next redirect).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc     redirect from a later stage
//   imem_req, imem_addr, imem_rdata instruction memory read interface
//   fetch_valid, fetch_pc,
//   fetch_instruction, fetch_fault  head of the fetch buffer
//   decode_ready                    decode consumes the head when valid
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_instruction,
  output logic            fetch_fault,
  input  logic            decode_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            issue;
  logic            push;
  logic            fifo_clear;
  logic            head_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign imem_addr = pc;
  assign pop       = head_valid && decode_ready;

  // Counting the in-flight request as occupied reserves a slot for its
  // response, so the buffer can never overflow.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign issue     = !reset && (state == S_RUN) && !redirect_valid &&
                     ((occupancy < (CW+1)'(DEPTH)) || pop);
  assign imem_req  = issue;

  // Clear wins over push and pop inside the FIFO; this is what kills the
  // in-flight response and discards a simultaneous pop on redirect/reset.
  assign fifo_clear = reset || redirect_valid;

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (inflight) begin
      push                   = 1'b1;
      push_entry.fault       = 1'b0;
      push_entry.pc          = inflight_pc;
      push_entry.instruction = imem_rdata;
    end else if (state == S_FAULT) begin
      push                   = 1'b1;
      push_entry.fault       = 1'b1;
      push_entry.pc          = pc;
      push_entry.instruction = NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= S_RUN;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      state    <= misaligned(redirect_pc) ? S_FAULT : S_RUN;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + INSTR_BYTES;
      end
      if (state == S_FAULT) state <= S_HALT;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk  (clk),
    .clear(fifo_clear),
    .push (push),
    .din  (push_entry),
    .pop  (pop),
    .valid(head_valid),
    .head (head),
    .count(count)
  );

  assign fetch_valid       = head_valid;
  assign fetch_pc          = head.pc;
  assign fetch_instruction = head.instruction;
  assign fetch_fault       = head.fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level model
// (queue of expected buffer entries, modelled pc and fetch mode).
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instruction;
  logic        fetch_fault;
  logic        decode_ready;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .fetch_instruction(fetch_instruction),
    .fetch_fault      (fetch_fault),
    .decode_ready     (decode_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Model state: mode 0 = fetching, 1 = fault entry pending, 2 = halted.
  ent_t        q[$];
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          was_reset;

  // Memory environment: answers the DUT's last request, else drives junk.
  bit          prev_req;
  logic [31:0] prev_addr;

  // Observed outputs of the latest cycle, for directed checks.
  logic        o_req, o_valid, o_fault;
  logic [31:0] o_addr, o_pc, o_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit dr);
    bit   pop;
    bit   exp_req;
    ent_t h;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    decode_ready   = dr;
    imem_rdata     = prev_req ? mem_word(prev_addr) : $urandom;
    @(negedge clk);
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = fetch_valid;
    o_pc    = fetch_pc;
    o_instr = fetch_instruction;
    o_fault = fetch_fault;

    pop     = (q.size() != 0) && dr;
    exp_req = !rst && (m_mode == 0) && !rv &&
              (((q.size() + int'(m_pend)) < int'(DEPTH)) || pop);
    chkb("imem_req", o_req, exp_req);
    chk("imem_addr", o_addr, m_pc);
    chkb("fetch_valid", o_valid, q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      chk("fetch_pc", o_pc, h.pc);
      chk("fetch_instruction", o_instr, h.instr);
      chkb("fetch_fault", o_fault, h.fault);
    end else if (was_reset) begin
      chk("reset_fetch_pc", o_pc, 32'h0);
      chk("reset_fetch_instruction", o_instr, 32'h0);
      chkb("reset_fetch_fault", o_fault, 1'b0);
    end
    prev_req  = o_req;
    prev_addr = o_addr;

    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pend = 1'b0;
      m_mode = 0;
      m_pc   = RST_PC;
    end else if (rv) begin
      q.delete();
      m_pend = 1'b0;
      m_pc   = rpc;
      m_mode = (rpc[1:0] != 2'b00) ? 1 : 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_pend) q.push_back({1'b0, m_pend_pc, imem_rdata});
      if (m_mode == 1) begin
        q.push_back({1'b1, m_pc, 32'h0000_0013});
        m_mode = 2;
      end
      m_pend = exp_req;
      if (exp_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end
    was_reset = rst;
    #1;
  endtask

  initial begin
    bit          r_rst, r_rv, r_dr;
    logic [31:0] r_pc;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    decode_ready   = 1'b1;
    imem_rdata     = '0;
    m_pc           = RST_PC;
    m_mode         = 0;
    m_pend         = 1'b0;
    m_pend_pc      = '0;
    was_reset      = 1'b1;
    prev_req       = 1'b0;
    prev_addr      = '0;
    @(posedge clk);
    #1;

    // Reset and release
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    chkb("rst_fetch_valid", o_valid, 1'b0);
    chkb("rst_imem_req", o_req, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rel_addr0", o_addr, 32'h0);
    chkb("rel_req0", o_req, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rel_addr4", o_addr, 32'h4);
    chkb("rel_valid_early", o_valid, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rel_addr8", o_addr, 32'h8);
    chkb("rel_first_valid", o_valid, 1'b1);
    chk("rel_first_pc", o_pc, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chkb("bp_req_stalled", o_req, 1'b0);
    chkb("bp_valid", o_valid, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with a request in flight
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    chkb("redir_req", o_req, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_addr", o_addr, 32'h0000_0100);
    chkb("redir_valid_n1", o_valid, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("redir_valid_n2", o_valid, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("redir_valid_n3", o_valid, 1'b1);
    chk("redir_pc_n3", o_pc, 32'h0000_0100);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect + full buffer + decode_ready together
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chkb("sim_full", o_valid, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("sim_empty", o_valid, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned redirect, halt, then recovery
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("mis_req_n1", o_req, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("mis_valid", o_valid, 1'b1);
    chkb("mis_fault", o_fault, 1'b1);
    chk("mis_instr", o_instr, 32'h0000_0013);
    chk("mis_pc", o_pc, 32'h0000_0102);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chkb("halt_req", o_req, 1'b0);
    chkb("halt_valid", o_valid, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("recover_addr", o_addr, 32'h0000_0200);
    chkb("recover_req", o_req, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // pc wrap
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_top", o_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr_zero", o_addr, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-operation
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("midrst_addr", o_addr, RST_PC);
    chkb("midrst_valid", o_valid, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(99) == 0);
      r_rv  = ($urandom_range(19) == 0);
      r_pc  = $urandom;
      if ($urandom_range(3) != 0) r_pc[1:0] = 2'b00;
      r_dr  = ($urandom_range(9) < 7);
      cycle(r_rst, r_rv, r_pc, r_dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
